// File: rtl/fq_pkg.sv
// Shared types and constants for the fetch pair queue.
package fq_pkg;
  localparam int PCW_DEF = 13;
  localparam int IW_DEF  = 32;

  typedef struct packed {
    logic [PCW_DEF-1:0] pc;
    logic [IW_DEF-1:0]  inst;
  } fq_entry_t;

  // Check stage treats an all-zero instruction as a bubble.
  localparam logic [31:0] NOP_INST = 32'd0;
endpackage

// File: rtl/fq_storage.sv
// Entry array with two write ports and two read ports; data is never reset.
module fq_storage
  import fq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = PCW_DEF + IW_DEF
) (
  input  logic                     clk_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  logic [W-1:0]             wdata1_i,
  input  logic                     we2_i,
  input  logic [$clog2(DEPTH)-1:0] waddr2_i,
  input  logic [W-1:0]             wdata2_i,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  output logic [W-1:0]             rdata1_o,
  input  logic [$clog2(DEPTH)-1:0] raddr2_i,
  output logic [W-1:0]             rdata2_o
);
  logic [W-1:0] mem_q [DEPTH];

  // The two write addresses are always consecutive, so they never collide.
  always_ff @(posedge clk_i) begin
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    if (we2_i) mem_q[waddr2_i] <= wdata2_i;
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];
endmodule

// File: rtl/fetch_pair_queue.sv
// Circular fetch queue: up to two enqueues and two dequeues per cycle,
// single-cycle flush, oldest two entries presented combinationally.
module fetch_pair_queue
  import fq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PCW   = PCW_DEF,
  parameter int IW    = IW_DEF
) (
  input  logic                   CLK,
  input  logic                   NRST,
  input  logic                   wr_valid1,
  input  logic                   wr_valid2,
  input  logic [PCW-1:0]         wr_pc1,
  input  logic [PCW-1:0]         wr_pc2,
  input  logic [IW-1:0]          wr_inst1,
  input  logic [IW-1:0]          wr_inst2,
  output logic                   wr_ready,
  output logic [PCW-1:0]         pc1_out,
  output logic [PCW-1:0]         pc2_out,
  output logic [IW-1:0]          inst1_out,
  output logic [IW-1:0]          inst2_out,
  output logic                   valid1,
  output logic                   valid2,
  input  logic [1:0]             deq_count,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PCW + IW;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    deq_req, eff_deq, enq;
  logic          enq_fire;
  logic [EW-1:0] rd1, rd2;

  assign wr_ready = (count_q <= READY_MAX);
  assign enq_fire = wr_ready & wr_valid1 & ~flush;

  always_comb begin
    deq_req = (deq_count == 2'd3) ? 2'd2 : deq_count;
    // Never retire more than is held; count is at most 1 whenever this clamps.
    eff_deq = (CW'(deq_req) > count_q) ? count_q[1:0] : deq_req;
    enq     = enq_fire ? (wr_valid2 ? 2'd2 : 2'd1) : 2'd0;
    head_d  = head_q + AW'(eff_deq);
    tail_d  = tail_q + AW'(enq);
    count_d = count_q + CW'(enq) - CW'(eff_deq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fq_storage #(.DEPTH(DEPTH), .W(EW)) u_storage (
    .clk_i    (CLK),
    .we1_i    (enq_fire),
    .waddr1_i (tail_q),
    .wdata1_i ({wr_pc1, wr_inst1}),
    .we2_i    (enq_fire & wr_valid2),
    .waddr2_i (tail_q + AW'(1)),
    .wdata2_i ({wr_pc2, wr_inst2}),
    .raddr1_i (head_q),
    .rdata1_o (rd1),
    .raddr2_i (head_q + AW'(1)),
    .rdata2_o (rd2)
  );

  assign valid1    = (count_q != '0);
  assign valid2    = (count_q >= CW'(2));
  assign pc1_out   = valid1 ? rd1[EW-1 -: PCW] : '0;
  assign pc2_out   = valid2 ? rd2[EW-1 -: PCW] : '0;
  assign inst1_out = valid1 ? rd1[IW-1:0] : IW'(NOP_INST);
  assign inst2_out = valid2 ? rd2[IW-1:0] : IW'(NOP_INST);
  assign count     = count_q;
endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed and randomised checks of fetch_pair_queue against a queue-based model.
module tb_fetch_pair_queue;
  import fq_pkg::*;

  localparam int DEPTH = 8;
  localparam int PCW   = 13;
  localparam int IW    = 32;

  logic           CLK = 1'b0;
  logic           NRST = 1'b0;
  logic           wr_valid1 = 1'b0, wr_valid2 = 1'b0;
  logic [PCW-1:0] wr_pc1 = '0, wr_pc2 = '0;
  logic [IW-1:0]  wr_inst1 = '0, wr_inst2 = '0;
  logic           wr_ready;
  logic [PCW-1:0] pc1_out, pc2_out;
  logic [IW-1:0]  inst1_out, inst2_out;
  logic           valid1, valid2;
  logic [1:0]     deq_count = '0;
  logic           flush = 1'b0;
  logic [3:0]     count;

  int n_checks = 0;
  int n_fail   = 0;

  fq_entry_t mq[$];

  fetch_pair_queue #(.DEPTH(DEPTH), .PCW(PCW), .IW(IW)) dut (
    .CLK(CLK), .NRST(NRST),
    .wr_valid1(wr_valid1), .wr_valid2(wr_valid2),
    .wr_pc1(wr_pc1), .wr_pc2(wr_pc2),
    .wr_inst1(wr_inst1), .wr_inst2(wr_inst2),
    .wr_ready(wr_ready),
    .pc1_out(pc1_out), .pc2_out(pc2_out),
    .inst1_out(inst1_out), .inst2_out(inst2_out),
    .valid1(valid1), .valid2(valid2),
    .deq_count(deq_count), .flush(flush), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a plain FIFO of entries updated from the queue's rules.
  always @(posedge CLK or negedge NRST) begin
    int sz;
    int d;
    bit rdy;
    if (!NRST) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      sz  = mq.size();
      rdy = (DEPTH - sz) >= 2;
      d   = (deq_count == 2'd3) ? 2 : int'(deq_count);
      if (d > sz) d = sz;
      repeat (d) void'(mq.pop_front());
      if (rdy && wr_valid1) begin
        mq.push_back('{pc: wr_pc1, inst: wr_inst1});
        if (wr_valid2) mq.push_back('{pc: wr_pc2, inst: wr_inst2});
      end
    end
  end

  always @(negedge CLK) begin
    int sz;
    sz = mq.size();
    chk("count",    64'(count),     64'(sz));
    chk("wr_ready", 64'(wr_ready),  64'((DEPTH - sz) >= 2));
    chk("valid1",   64'(valid1),    64'(sz >= 1));
    chk("valid2",   64'(valid2),    64'(sz >= 2));
    chk("pc1",      64'(pc1_out),   (sz >= 1) ? 64'(mq[0].pc)   : 64'd0);
    chk("inst1",    64'(inst1_out), (sz >= 1) ? 64'(mq[0].inst) : 64'd0);
    chk("pc2",      64'(pc2_out),   (sz >= 2) ? 64'(mq[1].pc)   : 64'd0);
    chk("inst2",    64'(inst2_out), (sz >= 2) ? 64'(mq[1].inst) : 64'd0);
  end

  task automatic cyc(input logic v1, input logic v2,
                     input logic [PCW-1:0] p1, input logic [IW-1:0] i1,
                     input logic [PCW-1:0] p2, input logic [IW-1:0] i2,
                     input logic [1:0] dq, input logic fl);
    wr_valid1 = v1; wr_valid2 = v2;
    wr_pc1 = p1; wr_inst1 = i1; wr_pc2 = p2; wr_inst2 = i2;
    deq_count = dq; flush = fl;
    @(posedge CLK);
    #1;
    wr_valid1 = 1'b0; wr_valid2 = 1'b0; deq_count = 2'd0; flush = 1'b0;
  endtask

  task automatic w(input logic v1, input logic v2,
                   input logic [PCW-1:0] p1, input logic [PCW-1:0] p2,
                   input logic [1:0] dq, input logic fl);
    cyc(v1, v2, p1, 32'h13 + 32'(p1), p2, 32'h13 + 32'(p2), dq, fl);
  endtask

  initial begin
    #12;
    chk("rst_count",  64'(count),     64'd0);
    chk("rst_valid1", 64'(valid1),    64'd0);
    chk("rst_valid2", 64'(valid2),    64'd0);
    chk("rst_inst1",  64'(inst1_out), 64'd0);
    chk("rst_ready",  64'(wr_ready),  64'd1);
    @(posedge CLK);
    #1 NRST = 1'b1;

    cyc(1, 1, 13'h000, 32'h00100093, 13'h004, 32'h00200113, 2'd0, 0);
    chk("t1_valid1", 64'(valid1),  64'd1);
    chk("t1_valid2", 64'(valid2),  64'd1);
    chk("t1_pc2",    64'(pc2_out), 64'h004);
    chk("t1_count",  64'(count),   64'd2);
    chk("t1_model",  64'(mq.size()), 64'd2);

    w(0, 0, 0, 0, 2'd1, 0);
    chk("t2_pc1",   64'(pc1_out),   64'h004);
    chk("t2_valid2",64'(valid2),    64'd0);
    chk("t2_count", 64'(count),     64'd1);
    chk("t2_inst2", 64'(inst2_out), 64'd0);
    chk("t2_inst1", 64'(inst1_out), 64'h00200113);

    w(1, 1, 13'h008, 13'h00C, 2'd0, 0);
    w(1, 1, 13'h010, 13'h014, 2'd0, 0);
    w(1, 1, 13'h018, 13'h01C, 2'd0, 0);
    chk("full_count", 64'(count),    64'd7);
    chk("full_ready", 64'(wr_ready), 64'd0);
    w(1, 1, 13'h200, 13'h204, 2'd2, 0);
    chk("drop_count", 64'(count),    64'd5);
    chk("drop_ready", 64'(wr_ready), 64'd1);
    chk("drop_pc1",   64'(pc1_out),  64'h00C);
    chk("drop_model", 64'(mq.size()), 64'd5);

    w(1, 1, 13'h0A0, 13'h0A4, 2'd1, 1);
    chk("flush_count",  64'(count),  64'd0);
    chk("flush_valid1", 64'(valid1), 64'd0);
    chk("flush_pc1",    64'(pc1_out), 64'd0);
    w(1, 1, 13'h300, 13'h304, 2'd0, 0);
    chk("post_flush_count", 64'(count), 64'd2);

    w(1, 1, 13'h308, 13'h30C, 2'd2, 0);
    w(1, 1, 13'h310, 13'h314, 2'd2, 0);
    w(1, 0, 13'h318, 13'h000, 2'd2, 0);
    w(0, 0, 0, 0, 2'd1, 0);
    chk("pre_wrap_count", 64'(count), 64'd0);
    w(1, 1, 13'h100, 13'h104, 2'd0, 0);
    chk("wrap_pc1",   64'(pc1_out), 64'h100);
    chk("wrap_pc2",   64'(pc2_out), 64'h104);
    chk("wrap_inst2", 64'(inst2_out), 64'h117);
    chk("wrap_count", 64'(count),   64'd2);

    w(0, 0, 0, 0, 2'd3, 0);
    chk("deq3_count", 64'(count), 64'd0);
    w(1, 0, 13'h120, 0, 2'd0, 0);
    w(0, 0, 0, 0, 2'd2, 0);
    chk("under1_count",  64'(count),  64'd0);
    chk("under1_valid1", 64'(valid1), 64'd0);
    w(0, 0, 0, 0, 2'd2, 0);
    chk("under0_count", 64'(count), 64'd0);
    w(0, 1, 13'h130, 13'h134, 2'd0, 0);
    chk("v2only_count", 64'(count), 64'd0);
    w(1, 1, 13'h140, 13'h144, 2'd0, 0);
    w(1, 1, 13'h148, 13'h14C, 2'd1, 0);
    chk("enqdeq_count", 64'(count),   64'd3);
    chk("enqdeq_pc1",   64'(pc1_out), 64'h144);

    for (int i = 0; i < 200; i++) begin
      w(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        13'($urandom), 13'($urandom), 2'($urandom_range(0, 3)),
        ($urandom_range(0, 15) == 0));
    end

    w(1, 1, 13'h400, 13'h404, 2'd0, 1);
    w(1, 1, 13'h500, 13'h504, 2'd0, 0);
    #2 NRST = 1'b0;
    #1;
    chk("arst_count",  64'(count),     64'd0);
    chk("arst_valid1", 64'(valid1),    64'd0);
    chk("arst_pc1",    64'(pc1_out),   64'd0);
    chk("arst_inst1",  64'(inst1_out), 64'd0);
    chk("arst_ready",  64'(wr_ready),  64'd1);
    #1 NRST = 1'b1;
    @(posedge CLK);
    #1;
    w(1, 1, 13'h600, 13'h604, 2'd0, 0);
    chk("post_rst_count", 64'(count),   64'd2);
    chk("post_rst_pc1",   64'(pc1_out), 64'h600);

    repeat (3) @(posedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_pair_queue.md
# fetch_pair_queue

Instruction fetch queue between instruction memory and the dual-issue dependency check stage. Fetch writes up to two {pc, inst} pairs per cycle. The queue presents the two oldest entries to the check stage every cycle. The check stage returns how many it issued (0, 1 or 2), and the queue retires exactly that many. A branch misprediction empties the queue in one cycle.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- PCW, 13, PC width in bits.
- IW, 32, instruction width in bits.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- NRST  in  1  reset, asynchronous, active-low.
- wr_valid1  in  1  fetch slot 1 carries an instruction.
- wr_valid2  in  1  fetch slot 2 carries an instruction; honoured only together with wr_valid1.
- wr_pc1, wr_pc2  in  PCW  PCs of the fetched instructions.
- wr_inst1, wr_inst2  in  IW  fetched instructions.
- wr_ready  out  1  queue has at least 2 free entries.
- pc1_out, pc2_out  out  PCW  PCs of the oldest and second-oldest entries.
- inst1_out, inst2_out  out  IW  oldest and second-oldest instructions.
- valid1, valid2  out  1  oldest / second-oldest entry present.
- deq_count  in  2  number of entries the check stage issues this cycle.
- flush  in  1  misprediction; discard all contents.
- count  out  log2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer with head pointer, tail pointer and occupancy counter. Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Read port (combinational from head):
  - slot 1 = entry[head]; slot 2 = entry[head+1].
  - valid1 = count ≥ 1; valid2 = count ≥ 2.
  - An invalid slot drives inst = 0 and pc = 0. The check stage treats inst 0 as a bubble.
- Dequeue:
  - eff_deq = min(deq_count, count). deq_count = 3 is treated as 2.
  - head += eff_deq.
- Enqueue:
  - Occurs only when wr_ready=1 and wr_valid1=1.
  - Writes entry[tail] = slot 1. If wr_valid2=1, also writes entry[tail+1] = slot 2.
  - tail += enq, where enq = 1 + wr_valid2.
  - wr_valid2 without wr_valid1 is ignored; no write occurs.
- wr_ready = (DEPTH − count) ≥ 2. It is computed from the current count and does not account for this cycle's dequeue.
- count_next = count + enq − eff_deq. Simultaneous enqueue and dequeue are both honoured in the same cycle.
- Flush has priority over everything:
  - head, tail and count are set to 0.
  - Any write in the same cycle is discarded; deq_count is ignored.
  - Storage contents are not cleared.
- Reset (NRST low, asynchronous):
  - head, tail, count = 0, so valid1 = valid2 = 0, inst/pc outputs = 0, and wr_ready = 1.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Enqueue-to-visible latency is 1 cycle. An entry written at edge N appears on slot 1 after edge N if the queue was empty.
- No bypass: an empty queue with a write in progress still shows valid1=0 during that cycle.
- Dequeue takes effect at the edge. The next entries appear combinationally after that edge.
- Flush asserted in cycle N gives empty outputs after edge N. A write in cycle N+1 is accepted normally.
- Full boundary: at count = DEPTH−1, wr_ready=0 even though one entry is free.
- Empty boundary: at count = 0, deq_count is ignored and the counters do not underflow.
- Wrap-around: a 2-wide write with tail = DEPTH−1 writes entries DEPTH−1 and 0. A 2-wide read wraps the same way.

## Structure
- A shared package `fq_pkg` holds:
  - PCW/IW defaults;
  - the fq_entry_t struct {pc, inst};
  - the constant NOP_INST = 32'd0 used for bubbles.
- One sub-module, `fq_storage`: DEPTH×(PCW+IW) register array with 2 write ports and 2 read ports, address-indexed, no reset on data.
- Pointer and count logic live in the top module.

## Test plan
- Reset, then write pc 0x000/inst 0x00100093 and pc 0x004/inst 0x00200113 → after one edge: valid1=valid2=1, pc2_out=0x004, count=2.
- With count=2, set deq_count=1 → slot 1 becomes pc 0x004, valid2=0, count=1, inst2_out=0.
- Fill to count=7 with DEPTH=8 → wr_ready=0; a 2-wide write that cycle is dropped; deq_count=2 → next cycle wr_ready=1.
- Wrap-around: with tail=7, write pcs 0x100/0x104 → entries 7 and 0 written; reading them 2-wide gives pc1_out=0x100, pc2_out=0x104.
- Flush with count=5 plus a simultaneous 2-wide write → count=0, valid1=0, write lost; a write on the next cycle gives count=2.
- With count=1, deq_count=2 → count=0, no underflow. Pulse NRST low mid-cycle → count=0 immediately, outputs 0.
